// File: rtl/fp_seq_pkg.sv
// Shared types for the FPU phase sequencer: phase encoding, one-hot decode, strobe-2 phase set.
package fp_seq_pkg;

  typedef enum logic [3:0] {
    P_IDLE, P_F1, P_F2, P_F3, P_F4, P_F5, P_F6, P_F7,
    P_F8, P_F9, P_F10, P_F11, P_F12, P_F13, P_ACC
  } phase_e;

  // Phases that also emit strob2_fp: F2, F5, F6
  localparam logic [13:1] S2_SET = 13'b0000000110010;

  function automatic logic [13:1] phase_onehot(phase_e p);
    logic [13:1] oh;
    oh = '0;
    for (int i = 1; i <= 13; i++)
      if (int'(p) == i) oh[i] = 1'b1;
    return oh;
  endfunction

  function automatic logic is_s2(phase_e p);
    return |(phase_onehot(p) & S2_SET);
  endfunction

endpackage

// File: rtl/fp_seq_strobe.sv
// Per-phase tick counter: strob_fp at tick 1, strob2_fp at tick 2, last-tick/advance flags.
// With FP_SEQ_STEP_EN defined, the last tick is held until step=1.
module fp_seq_strobe
  import fp_seq_pkg::*;
#(
  parameter int PHASE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic s2,
  input  logic step,
  output logic last,
  output logic adv,
  output logic strob_fp,
  output logic strob2_fp
);
  localparam int TW = (PHASE_TICKS > 4) ? $clog2(PHASE_TICKS) : 2;

  logic [TW-1:0] tick_q, tick_d;
  logic          hold;

`ifdef FP_SEQ_STEP_EN
  assign hold = last & ~step;
`else
  logic unused_step;
  assign unused_step = step;
  assign hold        = 1'b0;
`endif

  assign last      = run && (tick_q == TW'(PHASE_TICKS - 1));
  assign adv       = last & ~hold;
  // Strobes decode a fixed tick, so holding the last tick never repeats them
  assign strob_fp  = run && (tick_q == TW'(1));
  assign strob2_fp = run && s2 && (tick_q == TW'(2));

  always_comb begin
    tick_d = tick_q;
    if (!run)      tick_d = '0;
    else if (last) begin
      if (!hold)   tick_d = '0;
    end
    else           tick_d = tick_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_d;

endmodule

// File: rtl/fp_seq.sv
// FPU phase sequencer: accepts pufa|nrf, walks phases F1..F13 branching on F-PM indicators,
// ends with done or fp_int. Optional single-step via FP_SEQ_STEP_EN (see fp_seq_strobe).
module fp_seq
  import fp_seq_pkg::*;
#(
  parameter int PHASE_TICKS = 4,
  parameter int MAX_LOOP    = 64
) (
  input  logic        __clk,
  input  logic        clr_,
  input  logic        pufa,
  input  logic        nrf,
  input  logic        af_sf,
  input  logic        mw_mf,
  input  logic        dw_df,
  input  logic        g,
  input  logic        fic,
  input  logic        ws,
  input  logic        nz,
  input  logic        di,
  input  logic [3:0]  fi,
  input  logic        step,
  output logic [13:1] f,
  output logic        strob_fp,
  output logic        strob2_fp,
  output logic        _0_f,
  output logic        busy,
  output logic        done,
  output logic        fp_int
);
  localparam int LW = $clog2(MAX_LOOP + 1);

  phase_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [13:1]   f_q, f_d;
  logic          norm_q, norm_d, zf_q, zf_d, busy_q, busy_d;
  logic          done_q, done_d, fpint_q, fpint_d;
  logic          run, last, adv, lp;

  assign run = (state_q != P_IDLE) && (state_q != P_ACC);

  fp_seq_strobe #(.PHASE_TICKS(PHASE_TICKS)) u_strobe (
    .clk(__clk), .rst_n(clr_), .run(run), .s2(is_s2(state_q)), .step(step),
    .last(last), .adv(adv), .strob_fp(strob_fp), .strob2_fp(strob2_fp)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    norm_d  = norm_q;
    zf_d    = 1'b0;
    done_d  = 1'b0;
    fpint_d = 1'b0;
    lp      = 1'b0;
    case (state_q)
      P_IDLE: if (pufa | nrf) begin
        state_d = P_ACC;
        zf_d    = 1'b1;
        norm_d  = nrf;
        cnt_d   = '0;
      end
      P_ACC: state_d = norm_q ? P_F10 : P_F1;
      default: if (adv) begin
        case (state_q)
          P_F1:  state_d = P_F2;
          P_F2:  state_d = di ? P_F13 : (af_sf ? P_F5 : P_F4);
          P_F4:  state_d = P_F6;
          P_F5:  state_d = g ? P_F10 : P_F8;
          P_F6:  state_d = P_F7;
          P_F7:  state_d = ((mw_mf | dw_df) & ~fic) ? P_F8 : P_F9;
          P_F8:  if (fic) state_d = P_F6;
                 else begin state_d = P_F8; lp = 1'b1; end
          P_F9:  state_d = P_F10;
          P_F10: state_d = ws ? P_F7 : (nz ? P_F11 : P_F12);
          P_F11: begin state_d = P_F10; lp = 1'b1; end
          P_F12: state_d = P_F13;
          P_F13: begin
            state_d = P_IDLE;
            fpint_d = |fi;
            done_d  = ~|fi;
          end
          default: state_d = P_IDLE;
        endcase
        // Runaway F8/F11 iteration aborts through the exception path
        if (lp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LW'(MAX_LOOP)) begin
            state_d = P_IDLE;
            fpint_d = 1'b1;
          end
        end
      end
    endcase
    busy_d = (state_d != P_IDLE);
    f_d    = phase_onehot(state_d);
  end

  always_ff @(posedge __clk or negedge clr_)
    if (!clr_) begin
      state_q <= P_IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      norm_q  <= 1'b0;
      zf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fpint_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      norm_q  <= norm_d;
      zf_q    <= zf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fpint_q <= fpint_d;
    end

  assign f      = f_q;
  assign _0_f   = zf_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign fp_int = fpint_q;

endmodule
